// File: rtl/debug_uart_dump_if.sv
// -----------------------------------------------------------------------------
// debug_uart_dump_if
// Signal bundle between the debug capture buffer / host side and the UART
// readout stage.
//   start    host/buffer -> dump stage : rising edge requests a dump
//   data_in  buffer -> dump stage      : sample at the current read address
//   next     dump stage -> buffer      : one-cycle read-address advance pulse
//   uart_tx  dump stage -> host        : 8N1 serial line, idle high
//   busy     dump stage -> host        : dump in progress
//   done     dump stage -> host        : one-cycle end-of-dump pulse
// Modports: master = buffer/host side, slave = dump stage.
// -----------------------------------------------------------------------------
interface debug_uart_dump_if #(
  parameter int DWIDTH = 24
) ();
  logic              start;
  logic [DWIDTH-1:0] data_in;
  logic              next;
  logic              uart_tx;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output data_in,
    input  next,
    input  uart_tx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data_in,
    output next,
    output uart_tx,
    output busy,
    output done
  );
endinterface

// File: rtl/debug_uart_dump.sv
// -----------------------------------------------------------------------------
// debug_uart_dump
// Readout stage for the debug capture buffer. A rising edge on start walks all
// DEPTH buffer entries; each sample is sent MSB byte first as raw 8N1 UART
// frames. After every sample a one-cycle next pulse advances the buffer read
// address, and the stage waits RD_WAIT cycles for the new data to settle.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    debug_uart_dump_if.slave (start, data_in, next, uart_tx, busy, done)
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module debug_uart_dump #(
  parameter int DWIDTH       = 24,
  parameter int DEPTH        = 4096,
  parameter int CLKS_PER_BIT = 1085,
  parameter int RD_WAIT      = 4
) (
  input  logic              clk,
  input  logic              reset,
  debug_uart_dump_if.slave  bus
);

  localparam int NBYTES = (DWIDTH + 7) / 8;
  localparam int SWIDTH = NBYTES * 8;
  localparam int CW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW     = $clog2(CLKS_PER_BIT);
  localparam int WW     = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CW-1:0] LAST_SAMPLE = CW'(DEPTH - 1);
  localparam logic [BW-1:0] BIT_RELOAD  = BW'(CLKS_PER_BIT - 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(RD_WAIT - 1);
  localparam logic [IW-1:0] TOP_BYTE    = IW'(NBYTES - 1);
  localparam logic [3:0]    STOP_POS    = 4'd9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    LOAD   = 3'd2,
    TX     = 3'd3,
    ADV    = 3'd4
  } state_t;

  state_t            state_r;
  logic              start_d_r;
  logic [CW-1:0]     sample_cnt_r;
  logic [WW-1:0]     wait_cnt_r;
  logic [BW-1:0]     bit_cnt_r;
  logic [3:0]        bit_pos_r;     // 0 = start bit, 1..8 = data bits, 9 = stop bit
  logic [IW-1:0]     byte_idx_r;
  logic [SWIDTH-1:0] shift_r;
  logic              tx_r;
  logic              next_r;
  logic              busy_r;
  logic              done_r;

  logic              start_edge_s;
  logic [7:0]        cur_byte_s;

  // Line level for a given frame position of an 8N1 byte (LSB first).
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] pos);
    logic r;
    case (pos)
      4'd0:    r = 1'b0;
      4'd1:    r = b[0];
      4'd2:    r = b[1];
      4'd3:    r = b[2];
      4'd4:    r = b[3];
      4'd5:    r = b[4];
      4'd6:    r = b[5];
      4'd7:    r = b[6];
      4'd8:    r = b[7];
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Start edge detect and selection of the byte currently being framed.
  always_comb begin
    start_edge_s = bus.start & ~start_d_r;
    cur_byte_s   = shift_r[byte_idx_r*8 +: 8];
  end

  // Dump sequencer: sample walk, UART framing and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      start_d_r    <= 1'b0;
      sample_cnt_r <= '0;
      wait_cnt_r   <= '0;
      bit_cnt_r    <= '0;
      bit_pos_r    <= 4'd0;
      byte_idx_r   <= '0;
      shift_r      <= '0;
      tx_r         <= 1'b1;
      next_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      start_d_r <= bus.start;
      next_r    <= 1'b0;
      done_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_edge_s) begin
            state_r      <= SETTLE;
            busy_r       <= 1'b1;
            sample_cnt_r <= '0;
            wait_cnt_r   <= '0;
          end else begin
            busy_r <= 1'b0;
          end
        end
        SETTLE: begin
          if (wait_cnt_r == WAIT_LAST) begin
            state_r    <= LOAD;
            wait_cnt_r <= '0;
          end else begin
            wait_cnt_r <= wait_cnt_r + WW'(1);
          end
        end
        LOAD: begin
          // Zero-extension leaves the pad bits of the top byte at 0.
          shift_r    <= SWIDTH'(bus.data_in);
          byte_idx_r <= TOP_BYTE;
          bit_pos_r  <= 4'd0;
          bit_cnt_r  <= BIT_RELOAD;
          tx_r       <= 1'b0;
          state_r    <= TX;
        end
        TX: begin
          if (bit_cnt_r != '0) begin
            bit_cnt_r <= bit_cnt_r - BW'(1);
          end else begin
            bit_cnt_r <= BIT_RELOAD;
            if (bit_pos_r != STOP_POS) begin
              bit_pos_r <= bit_pos_r + 4'd1;
              tx_r      <= frame_bit(cur_byte_s, bit_pos_r + 4'd1);
            end else if (byte_idx_r != '0) begin
              // Next byte starts right after the stop bit, no idle gap.
              byte_idx_r <= byte_idx_r - IW'(1);
              bit_pos_r  <= 4'd0;
              tx_r       <= 1'b0;
            end else begin
              state_r <= ADV;
              tx_r    <= 1'b1;
              next_r  <= 1'b1;
              done_r  <= (sample_cnt_r == LAST_SAMPLE);
            end
          end
        end
        ADV: begin
          if (sample_cnt_r == LAST_SAMPLE) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            sample_cnt_r <= sample_cnt_r + CW'(1);
            state_r      <= SETTLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.next    = next_r;
  assign bus.uart_tx = tx_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_debug_uart_dump.sv
// -----------------------------------------------------------------------------
// tb_debug_uart_dump
// Directed bench for debug_uart_dump. Instance A: DWIDTH=24, DEPTH=4,
// CLKS_PER_BIT=4, RD_WAIT=2, fed by a buffer model with 1-cycle read latency.
// Instance B: DWIDTH=12, DEPTH=2, constant sample 0xABC.
// The serial line of each instance is logged once per cycle and decoded with
// fixed 4-cycle bit timing, sampling mid-bit.
// -----------------------------------------------------------------------------
module tb_debug_uart_dump;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  debug_uart_dump_if #(.DWIDTH(24)) bus_a ();
  debug_uart_dump_if #(.DWIDTH(12)) bus_b ();

  debug_uart_dump #(.DWIDTH(24), .DEPTH(4), .CLKS_PER_BIT(CPB), .RD_WAIT(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  debug_uart_dump #(.DWIDTH(12), .DEPTH(2), .CLKS_PER_BIT(CPB), .RD_WAIT(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Capture buffer model: read address advanced by next, 1-cycle read latency.
  logic [23:0] mem [4];
  logic [1:0]  rd_addr;
  always @(posedge clk) begin
    if (reset) rd_addr <= 2'd0;
    else if (bus_a.next) rd_addr <= rd_addr + 2'd1;
    bus_a.data_in <= mem[rd_addr];
  end
  assign bus_b.data_in = 12'hABC;

  // Per-cycle line log and pulse counters.
  bit tr_a[$];
  bit tr_b[$];
  int next_cnt_a = 0;
  int done_cnt_a = 0;
  int next_cnt_b = 0;
  int done_cnt_b = 0;
  always @(negedge clk) begin
    tr_a.push_back(bus_a.uart_tx);
    tr_b.push_back(bus_b.uart_tx);
    if (bus_a.next) next_cnt_a <= next_cnt_a + 1;
    if (bus_a.done) done_cnt_a <= done_cnt_a + 1;
    if (bus_b.next) next_cnt_b <= next_cnt_b + 1;
    if (bus_b.done) done_cnt_b <= done_cnt_b + 1;
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] dec_q[$];
  int frame_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decode 8N1 frames from a line log starting at index 'from'.
  task automatic decode(input bit tr[$], input int from);
    int i;
    logic [7:0] b;
    dec_q.delete();
    frame_err = 0;
    i = from;
    while (i + 10*CPB - 1 < tr.size()) begin
      if (tr[i] == 1'b0) begin
        if (tr[i + CPB/2] != 1'b0) frame_err++;
        for (int k = 0; k < 8; k++) b[k] = tr[i + CPB/2 + CPB*(k+1)];
        if (tr[i + CPB/2 + CPB*9] != 1'b1) frame_err++;
        dec_q.push_back(b);
        i += 10*CPB;
      end else begin
        i++;
      end
    end
  endtask

  task automatic pulse_start(input int which, input string tag);
    @(posedge clk) #1;
    if (which == 0) bus_a.start = 1'b1; else bus_b.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_busy_after_edge"}, (which == 0) ? bus_a.busy : bus_b.busy, 1);
    @(posedge clk) #1;
    if (which == 0) bus_a.start = 1'b0; else bus_b.start = 1'b0;
  endtask

  task automatic wait_done(input int which, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (((which == 0) ? bus_a.done : bus_b.done) == 1'b1) seen = 1'b1;
    end
    check_eq({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      check_eq({tag, "_busy_at_done"}, (which == 0) ? bus_a.busy : bus_b.busy, 1);
      @(negedge clk);
      check_eq({tag, "_busy_after_done"}, (which == 0) ? bus_a.busy : bus_b.busy, 0);
      check_eq({tag, "_done_one_cycle"}, (which == 0) ? bus_a.done : bus_b.done, 0);
    end
  endtask

  logic [7:0] exp2 [12] = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h01,
                            8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h00};
  logic [7:0] exp6 [4]  = '{8'h0A, 8'hBC, 8'h0A, 8'hBC};

  task automatic load_pattern();
    mem[0] = 24'hA1B2C3; mem[1] = 24'h000001; mem[2] = 24'hFFFFFF; mem[3] = 24'h800000;
  endtask

  task automatic check_bytes12(input string tag);
    check_eq({tag, "_nbytes"}, dec_q.size(), 12);
    check_eq({tag, "_framing"}, frame_err, 0);
    for (int k = 0; k < 12 && k < dec_q.size(); k++)
      check_eq($sformatf("%s_byte%0d", tag, k), dec_q[k], exp2[k]);
  endtask

  initial begin
    int t0, t1, n0, d0, s, bad;
    bit seen;
    reset = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    for (int k = 0; k < 4; k++) mem[k] = 24'h0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;

    // 1. reset state and quiet idle
    @(negedge clk);
    check_eq("rst_uart_tx", bus_a.uart_tx, 1);
    check_eq("rst_busy", bus_a.busy, 0);
    check_eq("rst_next", bus_a.next, 0);
    check_eq("rst_done", bus_a.done, 0);
    check_eq("rst_b_uart_tx", bus_b.uart_tx, 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus_a.uart_tx !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.next !== 1'b0 || bus_a.done !== 1'b0) bad++;
    end
    check_eq("idle_quiet_cycles", bad, 0);

    // 2. full dump of the pattern buffer
    load_pattern();
    n0 = next_cnt_a; d0 = done_cnt_a; t0 = tr_a.size();
    pulse_start(0, "dump");
    wait_done(0, "dump");
    repeat (5) @(negedge clk);
    decode(tr_a, t0);
    check_bytes12("dump");
    check_eq("dump_next_pulses", next_cnt_a - n0, 4);
    check_eq("dump_done_pulses", done_cnt_a - d0, 1);

    // 3. bit timing on 0x55 samples: strict 4-cycle alternation, no inter-byte gap
    for (int k = 0; k < 4; k++) mem[k] = 24'h555555;
    t0 = tr_a.size();
    pulse_start(0, "timing");
    wait_done(0, "timing");
    s = t0;
    while (s < tr_a.size() && tr_a[s] != 1'b0) s++;
    check_eq("timing_log_len", (tr_a.size() > s + 120) ? 1 : 0, 1);
    bad = 0;
    for (int i = 0; i < 120 && s + i < tr_a.size(); i++)
      if (tr_a[s + i] != (((i / CPB) % 2) == 1)) bad++;
    check_eq("timing_bad_cycles", bad, 0);
    if (s + 120 < tr_a.size()) check_eq("timing_idle_after_sample", tr_a[s + 120], 1);

    // 4. start held high: one dump only, then a fresh edge gives a second dump
    load_pattern();
    n0 = next_cnt_a; d0 = done_cnt_a; t0 = tr_a.size();
    @(posedge clk) #1 bus_a.start = 1'b1;
    wait_done(0, "held");
    repeat (200) @(negedge clk);
    check_eq("held_next_pulses", next_cnt_a - n0, 4);
    check_eq("held_done_pulses", done_cnt_a - d0, 1);
    check_eq("held_busy_low", bus_a.busy, 0);
    decode(tr_a, t0);
    check_bytes12("held1");
    @(posedge clk) #1 bus_a.start = 1'b0;
    repeat (3) @(posedge clk);
    t1 = tr_a.size();
    #1 bus_a.start = 1'b1;
    wait_done(0, "held2");
    #1 bus_a.start = 1'b0;
    repeat (5) @(negedge clk);
    decode(tr_a, t1);
    check_bytes12("held2");

    // 5. reset during the second byte of entry 1
    n0 = next_cnt_a;
    pulse_start(0, "rstmid");
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (bus_a.next) seen = 1'b1;
    end
    check_eq("rstmid_first_next", seen, 1);
    repeat (53) @(negedge clk);
    check_eq("rstmid_busy_before", bus_a.busy, 1);
    @(posedge clk) #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rstmid_uart_tx", bus_a.uart_tx, 1);
    check_eq("rstmid_busy", bus_a.busy, 0);
    check_eq("rstmid_next", bus_a.next, 0);
    n0 = next_cnt_a; d0 = done_cnt_a;
    @(posedge clk) #1 reset = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus_a.uart_tx !== 1'b1 || bus_a.busy !== 1'b0) bad++;
    end
    check_eq("rstmid_quiet_after", bad, 0);
    check_eq("rstmid_no_next", next_cnt_a - n0, 0);
    check_eq("rstmid_no_done", done_cnt_a - d0, 0);

    // 6. 12-bit samples: pad bits of the top byte are zero
    n0 = next_cnt_b; t0 = tr_b.size();
    pulse_start(1, "w12");
    wait_done(1, "w12");
    repeat (5) @(negedge clk);
    decode(tr_b, t0);
    check_eq("w12_nbytes", dec_q.size(), 4);
    check_eq("w12_framing", frame_err, 0);
    for (int k = 0; k < 4 && k < dec_q.size(); k++)
      check_eq($sformatf("w12_byte%0d", k), dec_q[k], exp6[k]);
    check_eq("w12_next_pulses", next_cnt_b - n0, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
